// File: rtl/prog_loader.sv
// Instruction-store writer: packs a byte stream into 9-bit words, writes them from
// address 0, verifies a trailing XOR checksum and holds the CPU in reset until done.
module prog_loader #(
   parameter int AW    = 6,
   parameter int IW    = 9,
   parameter int DEPTH = 64
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [AW:0]   Len,
   input  logic          In_valid,
   input  logic [7:0]    In_data,
   output logic          In_ready,
   output logic          Wen,
   output logic [AW-1:0] Waddr,
   output logic [IW-1:0] Wdat,
   output logic          Cpu_hold,
   output logic          Load_done,
   output logic          Err
);

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, LO, HI, WR, CHK, DONE} state_t;

   state_t      state, state_nx;
   logic        xfer;
   logic        start_acc;
   logic        len_bad;
   logic        done_nx;
   logic [AW:0] len_q;
   logic [AW:0] count;
   logic [AW:0] count_inc;
   logic [7:0]  chk;
   logic [7:0]  wlo;

   // Handshake and strobe are pure functions of state, never of In_valid.
   assign In_ready  = (state == LO) || (state == HI) || (state == CHK);
   assign Wen       = (state == WR);
   assign xfer      = In_valid && In_ready;
   assign start_acc = Start && ((state == IDLE) || (state == DONE));
   assign len_bad   = (Len > DEPTH_L);
   assign count_inc = count + 1'b1;
   assign done_nx   = (state_nx == DONE) && !start_acc;

   always_ff @(posedge Clk) begin
      if (!Reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: begin
            if (start_acc) begin
               if (Len == '0)   state_nx = CHK;
               else if (len_bad) state_nx = DONE;
               else              state_nx = LO;
            end
         end
         LO:  if (xfer) state_nx = HI;
         HI:  if (xfer) state_nx = WR;
         WR:  state_nx = (count_inc == len_q) ? CHK : LO;
         CHK: if (xfer) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         len_q     <= '0;
         count     <= '0;
         chk       <= '0;
         wlo       <= '0;
         Waddr     <= '0;
         Wdat      <= '0;
         Err       <= 1'b0;
         Cpu_hold  <= 1'b1;
         Load_done <= 1'b0;
      end else begin
         // A restart from DONE drops Load_done and re-asserts hold for at least a cycle.
         Load_done <= done_nx;
         Cpu_hold  <= !done_nx;
         if (start_acc) begin
            len_q <= Len;
            count <= '0;
            chk   <= '0;
            Err   <= len_bad;
         end
         case (state)
            LO: begin
               if (xfer) begin
                  wlo <= In_data;
                  chk <= chk ^ In_data;
               end
            end
            HI: begin
               if (xfer) begin
                  Wdat  <= IW'({In_data[0], wlo});
                  Waddr <= count[AW-1:0];
                  chk   <= chk ^ In_data;
                  if (In_data[7:1] != 7'd0) Err <= 1'b1;
               end
            end
            WR:  count <= count_inc;
            CHK: if (xfer && (In_data != chk)) Err <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised scoreboard bench for prog_loader: a queue-based reference model predicts
// every memory write and the final error flag; a negedge monitor checks them.
module tb_prog_loader;

   localparam int AW    = 6;
   localparam int IW    = 9;
   localparam int DEPTH = 64;

   logic          Clk = 1'b0;
   logic          Reset = 1'b0;
   logic          Start = 1'b0;
   logic [AW:0]   Len = '0;
   logic          In_valid = 1'b0;
   logic [7:0]    In_data = 8'hFF;
   logic          In_ready;
   logic          Wen;
   logic [AW-1:0] Waddr;
   logic [IW-1:0] Wdat;
   logic          Cpu_hold;
   logic          Load_done;
   logic          Err;

   prog_loader #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Len(Len),
      .In_valid(In_valid), .In_data(In_data), .In_ready(In_ready),
      .Wen(Wen), .Waddr(Waddr), .Wdat(Wdat),
      .Cpu_hold(Cpu_hold), .Load_done(Load_done), .Err(Err)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [IW-1:0] d;
   } wr_t;

   wr_t  exp_wr[$];
   logic exp_err[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Monitor: every write strobe and every rising Load_done is matched against the queues.
   logic ld_prev = 1'b0;
   wr_t  mon_w;
   logic mon_e;
   always @(negedge Clk) begin
      if (Wen) begin
         if (exp_wr.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_wen: got addr=%0d data=%03h expected no write", Waddr, Wdat);
         end else begin
            mon_w = exp_wr.pop_front();
            check("waddr", 32'(Waddr), 32'(mon_w.a));
            check("wdat", 32'(Wdat), 32'(mon_w.d));
         end
      end
      if (Load_done && !ld_prev) begin
         if (exp_err.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_done: got load_done=1 expected no completion");
         end else begin
            mon_e = exp_err.pop_front();
            check("err", 32'(Err), 32'(mon_e));
            check("cpu_hold_released", 32'(Cpu_hold), 32'd0);
         end
      end
      ld_prev = Load_done;
   end

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic do_start(input int len);
      Start = 1'b1;
      Len   = (AW+1)'(len);
      tick();
      Start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int smin, input int smax);
      int st;
      bit ok;
      st = (smax > 0) ? int'($urandom_range(smax, smin)) : 0;
      repeat (st) begin
         In_valid = 1'b0;
         In_data  = 8'hFF;
         tick();
      end
      In_valid = 1'b1;
      In_data  = b;
      ok = 1'b0;
      for (int g = 0; g < 20 && !ok; g++) begin
         if (In_ready) ok = 1'b1;
         tick();
      end
      In_valid = 1'b0;
      In_data  = 8'hFF;
      if (!ok) begin
         n_vec++; n_bad++;
         $display("FAIL in_ready_timeout: got in_ready=0 for 20 cycles expected 1 (byte %02h)", b);
      end
   endtask

   task automatic reset_check;
      check("rst_in_ready", 32'(In_ready), 32'd0);
      check("rst_wen", 32'(Wen), 32'd0);
      check("rst_waddr", 32'(Waddr), 32'd0);
      check("rst_wdat", 32'(Wdat), 32'd0);
      check("rst_cpu_hold", 32'(Cpu_hold), 32'd1);
      check("rst_load_done", 32'(Load_done), 32'd0);
      check("rst_err", 32'(Err), 32'd0);
   endtask

   // Reference model: word i = {hi[0], lo}; error if length too large, a high byte
   // carries bits above bit 0, or the checksum differs from the XOR of all data bytes.
   task automatic run_load(input int len, input logic [7:0] bytes[$], input logic [7:0] cs,
                           input int smin, input int smax);
      logic [7:0] x;
      bit e;
      bit seen;
      x = 8'h00;
      e = 1'b0;
      if (len > DEPTH) begin
         e = 1'b1;
      end else begin
         for (int i = 0; i < len; i++) begin
            x = x ^ bytes[2*i] ^ bytes[2*i+1];
            if (bytes[2*i+1][7:1] != 7'd0) e = 1'b1;
            exp_wr.push_back(wr_t'{AW'(i), IW'({bytes[2*i+1][0], bytes[2*i]})});
         end
         if (cs != x) e = 1'b1;
      end
      exp_err.push_back(e);
      do_start(len);
      if (len > DEPTH) begin
         check("ovf_in_ready_0", 32'(In_ready), 32'd0);
         tick();
         check("ovf_in_ready_1", 32'(In_ready), 32'd0);
         check("ovf_load_done", 32'(Load_done), 32'd1);
         tick();
         return;
      end
      check("load_cpu_hold", 32'(Cpu_hold), 32'd1);
      check("load_busy", 32'(Load_done), 32'd0);
      for (int i = 0; i < 2*len; i++) send_byte(bytes[i], smin, smax);
      send_byte(cs, smin, smax);
      seen = 1'b0;
      for (int g = 0; g < 5 && !seen; g++) begin
         if (Load_done) seen = 1'b1;
         else tick();
      end
      check("load_done_after_chk", 32'(Load_done), 32'd1);
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q[$];
      logic [7:0] lo, hi, x, cs;
      int len;
      bit ok;

      Reset = 1'b0;
      tick();
      tick();
      reset_check();
      Reset = 1'b1;
      tick();

      q = '{8'hA5, 8'h01, 8'h3C, 8'h00, 8'h00, 8'h01};
      run_load(3, q, 8'h99, 0, 0);
      run_load(3, q, 8'h98, 0, 0);
      run_load(3, q, 8'h99, 1, 4);
      run_load(65, q, 8'h00, 0, 0);
      q = '{8'h11, 8'h03, 8'h22, 8'h00};
      run_load(2, q, 8'h32, 0, 0);

      // Abort a Len=3 load by reset right after its first write.
      exp_wr.push_back(wr_t'{6'd0, 9'h1A5});
      do_start(3);
      send_byte(8'hA5, 0, 0);
      send_byte(8'h01, 0, 0);
      ok = 1'b0;
      for (int g = 0; g < 5 && !ok; g++) begin
         if (Wen) ok = 1'b1;
         else tick();
      end
      check("abort_first_wen", 32'(Wen), 32'd1);
      Reset = 1'b0;
      tick();
      reset_check();
      Reset = 1'b1;
      tick();
      q = '{8'h7F, 8'h00};
      run_load(1, q, 8'h7F, 0, 0);

      // Full-depth load reaches address DEPTH-1.
      q = {};
      x = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         lo = 8'($urandom);
         hi = 8'($urandom_range(1, 0));
         q.push_back(lo);
         q.push_back(hi);
         x = x ^ lo ^ hi;
      end
      run_load(DEPTH, q, x, 0, 1);

      for (int t = 0; t < 25; t++) begin
         case ($urandom_range(9, 0))
            0:       len = 0;
            1:       len = DEPTH + 1 + int'($urandom_range(62, 0));
            2:       len = DEPTH;
            default: len = int'($urandom_range(12, 1));
         endcase
         q = {};
         x = 8'h00;
         for (int i = 0; i < len && len <= DEPTH; i++) begin
            lo = 8'($urandom);
            hi = ($urandom_range(7, 0) == 0) ? 8'($urandom) : 8'($urandom_range(1, 0));
            q.push_back(lo);
            q.push_back(hi);
            x = x ^ lo ^ hi;
         end
         cs = ($urandom_range(3, 0) == 0) ? (x ^ 8'($urandom_range(255, 1))) : x;
         run_load(len, q, cs, 0, 3);
      end

      repeat (3) tick();
      check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
      check("err_queue_drained", 32'(exp_err.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
